// File: rtl/io_mcp23017_reader.sv
`default_nettype none
// ============================================================================
// Module   : io_mcp23017_reader
// Purpose  : I2C master that reads one MCP23017 register. The bus sequence is
//            START, write address, register pointer, repeated START, read
//            address, one data byte with master NACK, STOP. Bus timing
//            advances on rising edges of the slow clk_ic.
// Revision : 1.0 - initial release
// ============================================================================
module io_mcp23017_reader #(
   parameter logic [3:0] DEV_PREFIX = 4'b0100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_ic,
   input  logic       rd_en,
   input  logic [2:0] hardware_address,
   input  logic [7:0] register_address,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       nack_err,
   output logic       busy,
   output logic       SCK,
   output logic       SDA_oe,
   input  logic       SDA_in
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_TX_ADDR_W = 3'd2,
      ST_TX_REG    = 3'd3,
      ST_RSTART    = 3'd4,
      ST_TX_ADDR_R = 3'd5,
      ST_RX_DATA   = 3'd6,
      ST_STOP      = 3'd7
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] phase, phase_nxt;
   logic [3:0] bit_cnt, bit_cnt_nxt;
   logic [2:0] hw_q, hw_nxt;
   logic [7:0] reg_q, reg_nxt;
   logic [7:0] rx_sh, rx_sh_nxt;
   logic [7:0] data_nxt;
   logic       ack_smp, ack_nxt;
   logic       err, err_nxt;
   logic       sck_nxt, sda_oe_nxt, busy_nxt, valid_nxt, nack_nxt;
   logic [7:0] tx_byte;
   logic       tx_bit;
   logic       last_cell;
   logic       ic_s1, ic_s2, tick;
   logic       sda_s1, sda_s2;

   // Synchronise clk_ic and the SDA pin into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ic_s1  <= 1'b0;
         ic_s2  <= 1'b0;
         sda_s1 <= 1'b1;
         sda_s2 <= 1'b1;
      end else begin
         ic_s1  <= clk_ic;
         ic_s2  <= ic_s1;
         sda_s1 <= SDA_in;
         sda_s2 <= sda_s1;
      end
   end

   // One-clk tick on each 0->1 transition of the synchronised clk_ic.
   assign tick      = ic_s1 & ~ic_s2;
   assign last_cell = (bit_cnt == 4'd8);

   // Byte being transmitted in the current TX state and its current bit.
   always_comb begin
      tx_byte = 8'h00;
      case (state)
         ST_TX_ADDR_W: tx_byte = {DEV_PREFIX, hw_q, 1'b0};
         ST_TX_REG:    tx_byte = reg_q;
         ST_TX_ADDR_R: tx_byte = {DEV_PREFIX, hw_q, 1'b1};
         default:      tx_byte = 8'h00;
      endcase
      tx_bit = tx_byte[3'd7 - bit_cnt[2:0]];
   end

   // Next-state and bus-output logic; everything holds unless a tick arrives.
   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase;
      bit_cnt_nxt = bit_cnt;
      hw_nxt      = hw_q;
      reg_nxt     = reg_q;
      rx_sh_nxt   = rx_sh;
      data_nxt    = data_out;
      ack_nxt     = ack_smp;
      err_nxt     = err;
      sck_nxt     = SCK;
      sda_oe_nxt  = SDA_oe;
      busy_nxt    = busy;
      valid_nxt   = 1'b0;
      nack_nxt    = 1'b0;

      if (state == ST_IDLE) begin
         if (rd_en) begin
            hw_nxt      = hardware_address;
            reg_nxt     = register_address;
            busy_nxt    = 1'b1;
            err_nxt     = 1'b0;
            phase_nxt   = 2'd0;
            bit_cnt_nxt = 4'd0;
            state_nxt   = ST_START;
         end
      end else if (tick) begin
         phase_nxt = phase + 2'd1;
         case (state)
            ST_START, ST_RSTART: begin
               case (phase)
                  2'd0: sda_oe_nxt = 1'b0;
                  2'd1: sck_nxt    = 1'b1;
                  2'd2: sda_oe_nxt = 1'b1;
                  2'd3: begin
                     sck_nxt     = 1'b0;
                     bit_cnt_nxt = 4'd0;
                     state_nxt   = (state == ST_START) ? ST_TX_ADDR_W : ST_TX_ADDR_R;
                  end
               endcase
            end
            ST_TX_ADDR_W, ST_TX_REG, ST_TX_ADDR_R: begin
               case (phase)
                  2'd0: begin
                     sck_nxt    = 1'b0;
                     // ACK cell releases SDA so the slave can answer.
                     sda_oe_nxt = last_cell ? 1'b0 : ~tx_bit;
                  end
                  2'd1: sck_nxt = 1'b1;
                  2'd2: if (last_cell) ack_nxt = sda_s2;
                  2'd3: begin
                     sck_nxt = 1'b0;
                     if (last_cell) begin
                        bit_cnt_nxt = 4'd0;
                        if (ack_smp) begin
                           err_nxt   = 1'b1;
                           state_nxt = ST_STOP;
                        end else begin
                           case (state)
                              ST_TX_ADDR_W: state_nxt = ST_TX_REG;
                              ST_TX_REG:    state_nxt = ST_RSTART;
                              default:      state_nxt = ST_RX_DATA;
                           endcase
                        end
                     end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                     end
                  end
               endcase
            end
            ST_RX_DATA: begin
               case (phase)
                  2'd0: begin
                     sck_nxt    = 1'b0;
                     // Data cells and the final master NACK both leave SDA released.
                     sda_oe_nxt = 1'b0;
                  end
                  2'd1: sck_nxt = 1'b1;
                  2'd2: if (!last_cell) rx_sh_nxt = {rx_sh[6:0], sda_s2};
                  2'd3: begin
                     sck_nxt = 1'b0;
                     if (last_cell) begin
                        bit_cnt_nxt = 4'd0;
                        state_nxt   = ST_STOP;
                     end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                     end
                  end
               endcase
            end
            ST_STOP: begin
               case (phase)
                  2'd0: begin
                     sck_nxt    = 1'b0;
                     sda_oe_nxt = 1'b1;
                  end
                  2'd1: sck_nxt    = 1'b1;
                  2'd2: sda_oe_nxt = 1'b0;
                  2'd3: begin
                     busy_nxt  = 1'b0;
                     state_nxt = ST_IDLE;
                     if (err) begin
                        nack_nxt = 1'b1;
                     end else begin
                        data_nxt  = rx_sh;
                        valid_nxt = 1'b1;
                     end
                  end
               endcase
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State and output registers; reset abandons any transfer immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         phase    <= 2'd0;
         bit_cnt  <= 4'd0;
         hw_q     <= 3'd0;
         reg_q    <= 8'h00;
         rx_sh    <= 8'h00;
         data_out <= 8'h00;
         ack_smp  <= 1'b0;
         err      <= 1'b0;
         SCK      <= 1'b1;
         SDA_oe   <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         nack_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         bit_cnt  <= bit_cnt_nxt;
         hw_q     <= hw_nxt;
         reg_q    <= reg_nxt;
         rx_sh    <= rx_sh_nxt;
         data_out <= data_nxt;
         ack_smp  <= ack_nxt;
         err      <= err_nxt;
         SCK      <= sck_nxt;
         SDA_oe   <= sda_oe_nxt;
         busy     <= busy_nxt;
         valid    <= valid_nxt;
         nack_err <= nack_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_io_mcp23017_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_mcp23017_reader
// Purpose  : Bench for io_mcp23017_reader with an I2C slave model that logs
//            the decoded bus traffic (START, bytes with ACK/NACK, STOP).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_mcp23017_reader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clk_ic = 1'b0;
   logic       rd_en = 1'b0;
   logic [2:0] hardware_address = 3'd0;
   logic [7:0] register_address = 8'h00;
   wire  [7:0] data_out;
   wire        valid, nack_err, busy, SCK, SDA_oe;
   logic       slave_pull = 1'b0;
   wire        sda_line = ~SDA_oe & ~slave_pull;
   wire        SDA_in = sda_line;

   io_mcp23017_reader #(.DEV_PREFIX(4'b0100)) dut (
      .clk(clk), .rst_n(rst_n), .clk_ic(clk_ic), .rd_en(rd_en),
      .hardware_address(hardware_address), .register_address(register_address),
      .data_out(data_out), .valid(valid), .nack_err(nack_err), .busy(busy),
      .SCK(SCK), .SDA_oe(SDA_oe), .SDA_in(SDA_in)
   );

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // I2C timing clock, offset from clk edges; can be frozen.
   logic ic_hold = 1'b0;
   initial begin
      #2;
      forever begin
         #40;
         if (!ic_hold) clk_ic = ~clk_ic;
      end
   end

   int ic_rises = 0;
   int base = 0;
   always @(posedge clk_ic) ic_rises++;

   // Pulse monitors sampled just after each clk edge.
   int valid_hi = 0, nack_hi = 0, both_hi = 0;
   always @(posedge clk) begin
      #1;
      if (valid) valid_hi++;
      if (nack_err) nack_hi++;
      if (valid && nack_err) both_hi++;
   end

   // Slave model: modes 0 ok, 1 absent, 2 NACK register, 3 NACK read address.
   int         slv_mode = 0;
   logic [2:0] slv_hw = 3'd0;
   logic [7:0] slv_data = 8'h00;
   logic       sck_p = 1'b1, sda_p = 1'b1;
   int         bitn = 0, byte_idx = 0;
   logic [7:0] rx = 8'h00;
   logic       reading = 1'b0, rd_pending = 1'b0, matched = 1'b0;
   string      bus_str = "";

   always @(negedge clk) begin
      if (!rst_n) begin
         slave_pull = 1'b0; bitn = 0; byte_idx = 0; reading = 1'b0; rd_pending = 1'b0;
      end else if (sck_p && SCK && sda_p && !sda_line) begin
         bus_str = {bus_str, "S "};
         bitn = 0; byte_idx = 0; reading = 1'b0; rd_pending = 1'b0; slave_pull = 1'b0;
      end else if (sck_p && SCK && !sda_p && sda_line) begin
         bus_str = {bus_str, "P "};
         bitn = 0; reading = 1'b0; slave_pull = 1'b0;
      end else if (!sck_p && SCK) begin
         if (bitn < 8) begin
            rx = {rx[6:0], sda_line};
            bitn++;
         end else begin
            bus_str = {bus_str, $sformatf("%02x%s ", rx, sda_line ? "n" : "a")};
            bitn = 0;
            byte_idx++;
            if (rd_pending && !sda_line) reading = 1'b1;
            else reading = 1'b0;
            rd_pending = 1'b0;
         end
      end else if (sck_p && !SCK) begin
         if (bitn == 8) begin
            if (reading) slave_pull = 1'b0;
            else if (byte_idx == 0) begin
               matched = (slv_mode != 1) && (rx[7:1] == {4'b0100, slv_hw}) &&
                         !(rx[0] && slv_mode == 3);
               slave_pull = matched;
               rd_pending = matched && rx[0];
            end else slave_pull = matched && (slv_mode != 2);
         end else if (reading) slave_pull = ~slv_data[7 - bitn];
         else slave_pull = 1'b0;
      end
      sck_p = SCK;
      sda_p = sda_line;
   end

   // Reference: bus traffic a read must produce for a given slave behaviour.
   function automatic string exp_bus(input int mode, input logic [2:0] hw,
                                     input logic [7:0] rg, input logic [7:0] d);
      logic [7:0] aw, ar;
      string s;
      aw = {4'b0100, hw, 1'b0};
      ar = {4'b0100, hw, 1'b1};
      if (mode == 1) return {"S ", $sformatf("%02xn ", aw), "P "};
      s = {"S ", $sformatf("%02xa ", aw)};
      if (mode == 2) return {s, $sformatf("%02xn ", rg), "P "};
      s = {s, $sformatf("%02xa ", rg), "S "};
      if (mode == 3) return {s, $sformatf("%02xn ", ar), "P "};
      return {s, $sformatf("%02xa %02xn P ", ar, d)};
   endfunction

   // Reference: ticks = START + 36 per byte cell group + RSTART if reached + STOP.
   function automatic int exp_ticks(input int mode);
      int nbytes;
      nbytes = (mode == 1) ? 1 : (mode == 2) ? 2 : (mode == 3) ? 3 : 4;
      return 4 + 36 * nbytes + ((nbytes >= 3) ? 4 : 0) + 4;
   endfunction

   logic [7:0] exp_data = 8'h00;
   int         ticks;
   bit         timeout;

   task automatic wait_fall();
      logic prev;
      prev = clk_ic;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (prev && !clk_ic) break;
         prev = clk_ic;
      end
   endtask

   task automatic start_read(input int mode, input logic [2:0] hw, input logic [7:0] rg,
                             input logic [7:0] d, input bit align);
      slv_mode = mode; slv_hw = hw; slv_data = d;
      if (align) wait_fall();
      bus_str = "";
      hardware_address = hw;
      register_address = rg;
      rd_en = 1'b1;
      @(posedge clk);
      base = ic_rises;
      valid_hi = 0; nack_hi = 0; both_hi = 0;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic wait_done(input int poke, output int t, output bit to);
      bit poked;
      poked = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (poke > 0 && !poked && (ic_rises - base) == poke) begin
            register_address = 8'hFF;
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            poked = 1'b1;
         end
         if (!busy) begin
            to = 1'b0;
            break;
         end
      end
      t = ic_rises - base;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 6;
      if (SCK !== 1'b1) begin errors++; $display("FAIL reset_sck: got %b expected 1", SCK); end
      if (SDA_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", SDA_oe); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      if (nack_err !== 1'b0) begin errors++; $display("FAIL reset_nack: got %b expected 0", nack_err); end
      if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_read_ok();
      string e;
      e = exp_bus(0, 3'b010, 8'h13, 8'hA5);
      start_read(0, 3'b010, 8'h13, 8'hA5, 1'b1);
      wait_done(0, ticks, timeout);
      exp_data = 8'hA5;
      checks += 7;
      if (timeout) begin errors++; $display("FAIL ok_timeout: busy still %b", busy); end
      if (bus_str != e) begin errors++; $display("FAIL ok_bus: got '%s' expected '%s'", bus_str, e); end
      if (ticks !== 156) begin errors++; $display("FAIL ok_ticks: got %0d expected 156", ticks); end
      if (valid_hi !== 1) begin errors++; $display("FAIL ok_valid: got %0d cycles expected 1", valid_hi); end
      if (nack_hi !== 0) begin errors++; $display("FAIL ok_nack: got %0d cycles expected 0", nack_hi); end
      if (data_out !== exp_data) begin errors++; $display("FAIL ok_data: got %h expected %h", data_out, exp_data); end
      if (both_hi !== 0) begin errors++; $display("FAIL ok_both: got %0d expected 0", both_hi); end
   endtask

   task automatic test_nack_case(input int mode, input logic [7:0] rg);
      string e;
      logic [2:0] hw;
      hw = 3'($urandom_range(0, 7));
      e = exp_bus(mode, hw, rg, 8'h5A);
      start_read(mode, hw, rg, 8'h5A, 1'b1);
      wait_done(0, ticks, timeout);
      checks += 6;
      if (timeout) begin errors++; $display("FAIL nack%0d_timeout: busy still %b", mode, busy); end
      if (bus_str != e) begin errors++; $display("FAIL nack%0d_bus: got '%s' expected '%s'", mode, bus_str, e); end
      if (ticks !== exp_ticks(mode)) begin errors++; $display("FAIL nack%0d_ticks: got %0d expected %0d", mode, ticks, exp_ticks(mode)); end
      if (nack_hi !== 1) begin errors++; $display("FAIL nack%0d_pulse: got %0d cycles expected 1", mode, nack_hi); end
      if (valid_hi !== 0) begin errors++; $display("FAIL nack%0d_valid: got %0d cycles expected 0", mode, valid_hi); end
      if (data_out !== exp_data) begin errors++; $display("FAIL nack%0d_data: got %h expected %h", mode, data_out, exp_data); end
   endtask

   task automatic test_back_to_back();
      string e;
      e = exp_bus(0, 3'b101, 8'h21, 8'h96);
      start_read(0, 3'b101, 8'h21, 8'h96, 1'b1);
      wait_done(20, ticks, timeout);
      exp_data = 8'h96;
      checks += 3;
      if (bus_str != e) begin errors++; $display("FAIL ignore_bus: got '%s' expected '%s'", bus_str, e); end
      if (ticks !== 156) begin errors++; $display("FAIL ignore_ticks: got %0d expected 156", ticks); end
      if (data_out !== exp_data) begin errors++; $display("FAIL ignore_data: got %h expected %h", data_out, exp_data); end
      e = exp_bus(0, 3'b011, 8'h07, 8'h69);
      start_read(0, 3'b011, 8'h07, 8'h69, 1'b0);
      checks += 1;
      if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
      wait_done(0, ticks, timeout);
      exp_data = 8'h69;
      checks += 3;
      if (bus_str != e) begin errors++; $display("FAIL b2b_bus: got '%s' expected '%s'", bus_str, e); end
      if (ticks !== 156) begin errors++; $display("FAIL b2b_ticks: got %0d expected 156", ticks); end
      if (data_out !== exp_data) begin errors++; $display("FAIL b2b_data: got %h expected %h", data_out, exp_data); end
   endtask

   task automatic test_reset_abort();
      string e;
      start_read(0, 3'b001, 8'h09, 8'hC3, 1'b1);
      for (int i = 0; i < 2000 && (ic_rises - base) < 70; i++) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks += 4;
      if (SCK !== 1'b1) begin errors++; $display("FAIL abort_sck: got %b expected 1", SCK); end
      if (SDA_oe !== 1'b0) begin errors++; $display("FAIL abort_sda_oe: got %b expected 0", SDA_oe); end
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      if (data_out !== 8'h00) begin errors++; $display("FAIL abort_data: got %h expected 00", data_out); end
      exp_data = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      e = exp_bus(0, 3'b110, 8'h0A, 8'h3C);
      start_read(0, 3'b110, 8'h0A, 8'h3C, 1'b1);
      wait_done(0, ticks, timeout);
      exp_data = 8'h3C;
      checks += 3;
      if (bus_str != e) begin errors++; $display("FAIL after_abort_bus: got '%s' expected '%s'", bus_str, e); end
      if (ticks !== 156) begin errors++; $display("FAIL after_abort_ticks: got %0d expected 156", ticks); end
      if (data_out !== exp_data) begin errors++; $display("FAIL after_abort_data: got %h expected %h", data_out, exp_data); end
   endtask

   task automatic test_freeze();
      string e;
      logic s0, d0;
      int bad;
      e = exp_bus(0, 3'b100, 8'h14, 8'h81);
      start_read(0, 3'b100, 8'h14, 8'h81, 1'b1);
      for (int i = 0; i < 2000 && (ic_rises - base) < 50; i++) @(negedge clk);
      wait_fall();
      ic_hold = 1'b1;
      @(negedge clk);
      s0 = SCK; d0 = SDA_oe;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (SCK !== s0 || SDA_oe !== d0 || busy !== 1'b1) bad++;
      end
      checks += 1;
      if (bad !== 0) begin errors++; $display("FAIL freeze_hold: got %0d changed cycles expected 0", bad); end
      ic_hold = 1'b0;
      wait_done(0, ticks, timeout);
      exp_data = 8'h81;
      checks += 4;
      if (bus_str != e) begin errors++; $display("FAIL freeze_bus: got '%s' expected '%s'", bus_str, e); end
      if (ticks !== 156) begin errors++; $display("FAIL freeze_ticks: got %0d expected 156", ticks); end
      if (data_out !== exp_data) begin errors++; $display("FAIL freeze_data: got %h expected %h", data_out, exp_data); end
      if (valid_hi !== 1) begin errors++; $display("FAIL freeze_valid: got %0d cycles expected 1", valid_hi); end
   endtask

   task automatic test_random();
      string e;
      int mode;
      logic [2:0] hw;
      logic [7:0] rg, d;
      for (int n = 0; n < 8; n++) begin
         mode = $urandom_range(0, 3);
         hw = 3'($urandom_range(0, 7));
         rg = 8'($urandom);
         d = 8'($urandom);
         e = exp_bus(mode, hw, rg, d);
         start_read(mode, hw, rg, d, 1'b1);
         wait_done(0, ticks, timeout);
         if (mode == 0) exp_data = d;
         checks += 5;
         if (bus_str != e) begin errors++; $display("FAIL rnd%0d_bus: got '%s' expected '%s'", n, bus_str, e); end
         if (ticks !== exp_ticks(mode)) begin errors++; $display("FAIL rnd%0d_ticks: got %0d expected %0d", n, ticks, exp_ticks(mode)); end
         if (data_out !== exp_data) begin errors++; $display("FAIL rnd%0d_data: got %h expected %h", n, data_out, exp_data); end
         if (valid_hi !== ((mode == 0) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_valid: got %0d cycles expected %0d", n, valid_hi, (mode == 0) ? 1 : 0); end
         if (nack_hi !== ((mode == 0) ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_nack: got %0d cycles expected %0d", n, nack_hi, (mode == 0) ? 0 : 1); end
      end
   endtask

   initial begin
      test_reset();
      test_read_ok();
      test_nack_case(1, 8'h13);
      test_nack_case(2, 8'h12);
      test_nack_case(3, 8'h05);
      test_back_to_back();
      test_reset_abort();
      test_freeze();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/io_mcp23017_reader.md
Name: io_mcp23017_reader

Overview:
- I2C master that reads one register of an MCP23017 port expander.
- Read counterpart of the existing MCP23017 register writer; sits beside it in top-levels that need pin inputs, for example button or switch banks forwarded over UART.
- Transaction sequence: START, write device address, register pointer, repeated START, read device address, one data byte with master NACK, STOP.
- Bus timing comes from the same slow clk_ic that counter_clock produces.

Parameters:
- DEV_PREFIX, 4'b0100, fixed upper nibble of the 7-bit MCP23017 address.

Ports:
- clk  input  1  system clock; all logic is synchronous to it.
- rst_n  input  1  asynchronous, active-low reset.
- clk_ic  input  1  I2C timing clock; sampled in the clk domain.
- rd_en  input  1  request strobe; accepted only while busy=0.
- hardware_address  input  3  device pins A2..A0; latched on acceptance.
- register_address  input  8  register to read; latched on acceptance.
- data_out  output  8  last successfully read byte.
- valid  output  1  one-clk pulse when data_out is updated.
- nack_err  output  1  one-clk pulse when the slave does not acknowledge.
- busy  output  1  high from acceptance until the transaction ends.
- SCK  output  1  I2C clock; 1 = released/high.
- SDA_oe  output  1  1 = pull SDA low, 0 = release (external open-drain buffer).
- SDA_in  input  1  SDA pin level.

Behaviour:
- Reset (asynchronous, immediate):
  - SCK=1, SDA_oe=0, busy=0, valid=0, nack_err=0, data_out=8'h00, state IDLE.
  - Reset mid-transaction abandons the transfer with no STOP generated.
- Tick generation:
  - clk_ic is registered through 2 flops; a tick is a 0->1 transition, one clk wide.
  - All bus activity advances only on ticks. If clk_ic is constant, the FSM freezes.
- Acceptance:
  - In IDLE, rd_en=1 latches the inputs and sets busy=1 on the next clk.
  - rd_en while busy=1 is ignored; there is no queueing.
- Phase counter: 2-bit counter p0..p3, one phase per tick.
- Bit cell (4 ticks):
  - p0: SCK=0, drive SDA (SDA_oe = ~bit; for read or ACK cells SDA_oe=0).
  - p1: SCK=1.
  - p2: sample SDA_in.
  - p3: SCK=0.
- START / repeated START (4 ticks):
  - p0: SDA_oe=0, SCK unchanged.
  - p1: SCK=1.
  - p2: SDA_oe=1.
  - p3: SCK=0.
- STOP (4 ticks):
  - p0: SCK=0, SDA_oe=1.
  - p1: SCK=1.
  - p2: SDA_oe=0.
  - p3: return to IDLE.
- FSM states: IDLE -> START -> TX_ADDR_W -> TX_REG -> RSTART -> TX_ADDR_R -> RX_DATA -> STOP -> IDLE.
- TX states:
  - Send 8 bits MSB first, then 1 ACK cell with SDA released.
  - If the ACK sample is 1 (NACK), set an error flag and go to STOP.
- Address bytes:
  - Write address = {DEV_PREFIX, hardware_address, 1'b0}.
  - Read address = {DEV_PREFIX, hardware_address, 1'b1}.
- RX_DATA:
  - Sample 8 bits MSB first into a shift register.
  - The 9th cell is driven as NACK (SDA_oe=0).
- Completion (on STOP p3):
  - busy=0 on the same clk edge.
  - No error: data_out takes the shift register and valid pulses for 1 clk.
  - Error: nack_err pulses for 1 clk and data_out is unchanged.
  - valid and nack_err are never high together.
- Latency in ticks, counted from the first tick after acceptance to STOP p3:
  - Successful read: 156 (START 4 + 3x36 + RSTART 4 + read 36 + STOP 4).
  - NACK on the write address: 44.
  - NACK on the register byte: 80.
  - NACK on the read address: 120.
- A new rd_en is accepted on the clk after busy falls.

Test Plan:
- hw=3'b010, reg=8'h13, slave ACKs all and returns 8'hA5 -> bus bytes 8'h44, 8'h13, RSTART, 8'h45; master NACK and STOP; valid pulses once; data_out=8'hA5; 156 ticks; nack_err never set.
- No slave (SDA_in=1 always), rd_en -> nack_err pulses after 44 ticks with a STOP on the bus; data_out keeps its prior value; busy=0.
- Slave ACKs the address but NACKs reg 8'h12 -> STOP follows the 2nd byte; nack_err at 80 ticks; no RSTART seen.
- rd_en pulsed again at tick 20 with reg 8'hFF -> ignored; the bus shows only the original register byte. rd_en on the clk after busy falls -> a new START at the next tick.
- rst_n low at tick 70 -> SCK=1 and SDA_oe=0 immediately, busy=0. A fresh read after release completes normally with 8'h3C.
- clk_ic held low for 1000 clks mid-byte -> SCK and SDA_oe unchanged and busy stays 1. Resuming the toggles completes correctly.
